// File: rtl/pwm_sched_pkg.sv
// Shared state encodings and default sizing for the PWM duty scheduler.
package pwm_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RAMP = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEF_DUTY_MAX  = 10;
  localparam int DEF_DUTY_INIT = 5;

endpackage

// File: rtl/pwm_duty_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import pwm_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Arbitrates duty-cycle requests round-robin and slews duty_out by one count
// per STEP_DIV PWM period boundaries toward the accepted, clamped target.
module pwm_duty_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DUTY_W    = 4,
  parameter int DUTY_MAX  = DEF_DUTY_MAX,
  parameter int DUTY_INIT = DEF_DUTY_INIT,
  parameter int STEP_DIV  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DUTY_W-1:0]   req_duty,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        period_end,
  output logic [DUTY_W-1:0]           duty_out,
  output logic [DUTY_W-1:0]           target_out,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        done
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int SCW = $clog2(STEP_DIV + 1);
  localparam logic [DUTY_W-1:0] MAXV  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INITV = DUTY_W'(DUTY_INIT);

  state_t             state;
  state_t             state_next;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic               win_any;
  logic [SCW-1:0]     step_cnt;
  logic [DUTY_W-1:0]  win_duty;
  logic [DUTY_W-1:0]  win_clamped;
  logic [DUTY_W-1:0]  duty_step;
  logic               grant_ok;
  logic               step_now;
  logic               step_last;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // The grant is gated by rst so req_ready reads low for the whole reset window.
  assign grant_ok    = (state == ST_IDLE) && en && !rst && win_any;
  assign req_ready   = grant_ok ? win_grant : '0;
  assign win_duty    = req_duty[int'(win_idx)*DUTY_W +: DUTY_W];
  assign win_clamped = (win_duty > MAXV) ? MAXV : win_duty;

  assign step_now  = (state == ST_RAMP) && en && period_end;
  assign step_last = (step_cnt == SCW'(STEP_DIV - 1));
  assign duty_step = (target_out > duty_out) ? duty_out + DUTY_W'(1)
                                             : duty_out - DUTY_W'(1);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_ok) state_next = (win_clamped != duty_out) ? ST_RAMP : ST_DONE;
      ST_RAMP: if (step_now && step_last && duty_step == target_out) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered copies of the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      duty_out   <= INITV;
      target_out <= INITV;
      grant_id   <= '0;
      rr_ptr     <= '0;
      step_cnt   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_RAMP);
      done  <= (state_next == ST_DONE);
      if (grant_ok) begin
        target_out <= win_clamped;
        grant_id   <= win_idx;
        rr_ptr     <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
      end
      if (step_now) begin
        if (step_last) begin
          duty_out <= duty_step;
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + SCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed testbench for pwm_duty_scheduler: default instance plus a STEP_DIV=2 instance.
module tb_pwm_duty_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [15:0] req_duty;
  logic [3:0]  req_ready;
  logic        period_end;
  logic [3:0]  duty_out;
  logic [3:0]  target_out;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done;

  logic        en2;
  logic [3:0]  req_valid2;
  logic [15:0] req_duty2;
  logic [3:0]  req_ready2;
  logic        period_end2;
  logic [3:0]  duty_out2;
  logic [3:0]  target_out2;
  logic [1:0]  grant_id2;
  logic        busy2;
  logic        done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_duty_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_duty(req_duty),
    .req_ready(req_ready), .period_end(period_end), .duty_out(duty_out),
    .target_out(target_out), .grant_id(grant_id), .busy(busy), .done(done)
  );

  pwm_duty_scheduler #(.STEP_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .req_valid(req_valid2), .req_duty(req_duty2),
    .req_ready(req_ready2), .period_end(period_end2), .duty_out(duty_out2),
    .target_out(target_out2), .grant_id(grant_id2), .busy(busy2), .done(done2)
  );

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    period_end = 1'b1;
    clk_n(1);
    period_end = 1'b0;
  endtask

  task automatic pulse2();
    period_end2 = 1'b1;
    clk_n(1);
    period_end2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; period_end = 1'b0;
    req_valid = 4'b1010; req_duty = '0;
    req_duty[1*4 +: 4] = 4'd3;
    req_duty[3*4 +: 4] = 4'd3;
    en2 = 1'b1; req_valid2 = '0; req_duty2 = '0; period_end2 = 1'b0;
    #3;
    tests++; if (duty_out !== 4'd5) begin fails++; $display("[TB] FAIL reset_duty got %0d exp 5", duty_out); end
    tests++; if (target_out !== 4'd5) begin fails++; $display("[TB] FAIL reset_target got %0d exp 5", target_out); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ready got %b exp 0000", req_ready); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy_done got %b%b exp 00", busy, done); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_grant_id got %0d exp 0", grant_id); end
    clk_n(2);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ready_held got %b exp 0000", req_ready); end
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("[TB] FAIL first_grant got %b exp 0010", req_ready); end
  endtask

  task automatic test_round_robin();
    clk_n(1);
    tests++; if (target_out !== 4'd3 || grant_id !== 2'd1) begin fails++; $display("[TB] FAIL rr_accept1 got t=%0d id=%0d exp t=3 id=1", target_out, grant_id); end
    tests++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL rr_ramp_state got busy=%b ready=%b exp 1 0000", busy, req_ready); end
    pulse();
    tests++; if (duty_out !== 4'd4) begin fails++; $display("[TB] FAIL rr_step1 got %0d exp 4", duty_out); end
    clk_n(2);
    pulse();
    tests++; if (duty_out !== 4'd3 || done !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL rr_done1 got d=%0d done=%b busy=%b exp 3 1 0", duty_out, done, busy); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL rr_no_grant_in_done got %b exp 0000", req_ready); end
    clk_n(1);
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("[TB] FAIL rr_second_grant got %b exp 1000", req_ready); end
    clk_n(1);
    tests++; if (done !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd3) begin fails++; $display("[TB] FAIL rr_equal_target got done=%b busy=%b id=%0d exp 1 0 3", done, busy, grant_id); end
    clk_n(1);
    req_valid = 4'b0011;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL rr_wrap got %b exp 0001", req_ready); end
    req_valid = 4'b0000;
    clk_n(1);
    tests++; if (busy !== 1'b0 || done !== 1'b0 || grant_id !== 2'd3) begin fails++; $display("[TB] FAIL rr_no_transfer got busy=%b done=%b id=%0d exp 0 0 3", busy, done, grant_id); end
  endtask

  task automatic test_reset_midcycle();
    #3;
    rst = 1'b1;
    #1;
    tests++; if (duty_out !== 4'd5 || target_out !== 4'd5) begin fails++; $display("[TB] FAIL midcycle_reset got d=%0d t=%0d exp 5 5", duty_out, target_out); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("[TB] FAIL midcycle_reset_id got %0d exp 0", grant_id); end
    clk_n(1);
    rst = 1'b0;
    clk_n(1);
  endtask

  task automatic test_ramp_up();
    logic [3:0] exp_d;
    req_duty[0*4 +: 4] = 4'd8;
    req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL up_grant got %b exp 0001", req_ready); end
    clk_n(1);
    req_valid = 4'b0000;
    tests++; if (target_out !== 4'd8 || busy !== 1'b1) begin fails++; $display("[TB] FAIL up_accept got t=%0d busy=%b exp 8 1", target_out, busy); end
    for (int k = 0; k < 3; k++) begin
      clk_n(9);
      pulse();
      exp_d = 4'd6 + 4'(k);
      tests++; if (duty_out !== exp_d) begin fails++; $display("[TB] FAIL up_step%0d got %0d exp %0d", k, duty_out, exp_d); end
      tests++; if (done !== (k == 2)) begin fails++; $display("[TB] FAIL up_done%0d got %b exp %b", k, done, (k == 2)); end
    end
    clk_n(1);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL up_done_once got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_clamp();
    logic [3:0] exp_d;
    req_duty[2*4 +: 4] = 4'd15;
    req_valid = 4'b0100;
    clk_n(1);
    req_valid = 4'b0000;
    tests++; if (target_out !== 4'd10 || grant_id !== 2'd2) begin fails++; $display("[TB] FAIL clamp_target got t=%0d id=%0d exp 10 2", target_out, grant_id); end
    pulse();
    clk_n(2);
    pulse();
    tests++; if (duty_out !== 4'd10 || done !== 1'b1) begin fails++; $display("[TB] FAIL clamp_reach got d=%0d done=%b exp 10 1", duty_out, done); end
    clk_n(2);
    pulse();
    tests++; if (duty_out !== 4'd10) begin fails++; $display("[TB] FAIL clamp_idle_pulse got %0d exp 10", duty_out); end
    req_duty[3*4 +: 4] = 4'd0;
    req_valid = 4'b1000;
    clk_n(1);
    req_valid = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      clk_n(2);
      pulse();
      exp_d = 4'd10 - 4'(k);
      tests++; if (duty_out !== exp_d) begin fails++; $display("[TB] FAIL down_step%0d got %0d exp %0d", k, duty_out, exp_d); end
    end
    tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL down_done got %b exp 1", done); end
    clk_n(1);
  endtask

  task automatic test_enable();
    req_duty[0*4 +: 4] = 4'd4;
    req_valid = 4'b0001;
    clk_n(1);
    req_valid = 4'b0000;
    pulse();
    tests++; if (duty_out !== 4'd1) begin fails++; $display("[TB] FAIL en_first_step got %0d exp 1", duty_out); end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clk_n(2);
      pulse();
      tests++; if (duty_out !== 4'd1 || busy !== 1'b1) begin fails++; $display("[TB] FAIL en_hold%0d got d=%0d busy=%b exp 1 1", k, duty_out, busy); end
    end
    en = 1'b1;
    clk_n(2);
    pulse();
    tests++; if (duty_out !== 4'd2) begin fails++; $display("[TB] FAIL en_resume got %0d exp 2", duty_out); end
    clk_n(2); pulse();
    clk_n(2); pulse();
    tests++; if (duty_out !== 4'd4 || done !== 1'b1) begin fails++; $display("[TB] FAIL en_finish got d=%0d done=%b exp 4 1", duty_out, done); end
    clk_n(1);
    en = 1'b0;
    req_valid = 4'b0010;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL en_low_no_grant got %b exp 0000", req_ready); end
    clk_n(2);
    tests++; if (busy !== 1'b0 || grant_id !== 2'd0) begin fails++; $display("[TB] FAIL en_low_no_transfer got busy=%b id=%0d exp 0 0", busy, grant_id); end
    req_valid = 4'b0000;
    en = 1'b1;
  endtask

  task automatic test_reset_mid_ramp();
    req_duty[1*4 +: 4] = 4'd9;
    req_valid = 4'b0010;
    clk_n(1);
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      clk_n(2);
      pulse();
    end
    tests++; if (duty_out !== 4'd7 || busy !== 1'b1) begin fails++; $display("[TB] FAIL abort_pre got d=%0d busy=%b exp 7 1", duty_out, busy); end
    #3;
    rst = 1'b1;
    #1;
    tests++; if (duty_out !== 4'd5 || target_out !== 4'd5 || busy !== 1'b0 || done !== 1'b0 || grant_id !== 2'd0) begin
      fails++; $display("[TB] FAIL abort_reset got d=%0d t=%0d busy=%b done=%b id=%0d exp 5 5 0 0 0", duty_out, target_out, busy, done, grant_id);
    end
    pulse();
    clk_n(1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clk_n(1);
      tests++; if (done !== 1'b0 || busy !== 1'b0 || duty_out !== 4'd5) begin fails++; $display("[TB] FAIL abort_quiet%0d got done=%b busy=%b d=%0d exp 0 0 5", k, done, busy, duty_out); end
    end
  endtask

  task automatic test_step_div2();
    req_duty2[0*4 +: 4] = 4'd7;
    req_valid2 = 4'b0001;
    #1;
    tests++; if (req_ready2 !== 4'b0001) begin fails++; $display("[TB] FAIL div2_grant got %b exp 0001", req_ready2); end
    clk_n(1);
    req_valid2 = 4'b0000;
    pulse2();
    tests++; if (duty_out2 !== 4'd5) begin fails++; $display("[TB] FAIL div2_pulse1 got %0d exp 5", duty_out2); end
    clk_n(2); pulse2();
    tests++; if (duty_out2 !== 4'd6) begin fails++; $display("[TB] FAIL div2_pulse2 got %0d exp 6", duty_out2); end
    clk_n(2); pulse2();
    tests++; if (duty_out2 !== 4'd6 || busy2 !== 1'b1) begin fails++; $display("[TB] FAIL div2_pulse3 got d=%0d busy=%b exp 6 1", duty_out2, busy2); end
    clk_n(2); pulse2();
    tests++; if (duty_out2 !== 4'd7 || done2 !== 1'b1) begin fails++; $display("[TB] FAIL div2_pulse4 got d=%0d done=%b exp 7 1", duty_out2, done2); end
    clk_n(1);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset_midcycle();
    test_ramp_up();
    test_clamp();
    test_enable();
    test_reset_mid_ramp();
    test_step_div2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_duty_scheduler.md
# pwm_duty_scheduler

Controller that shares the PWM duty-cycle setting between several requesters and slews the PWM generator's duty value toward the granted target. It sits between requester logic (buttons, host registers, test sequencers) and the PWM datapath. It arbitrates requests round-robin, accepts one target at a time, and steps `duty_out` by ±1 only at PWM period boundaries so the output never glitches mid-period.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8)
- `DUTY_W`, 4: width of duty values
- `DUTY_MAX`, 10: PWM period length in counts; upper clamp for duty
- `DUTY_INIT`, 5: reset value of `duty_out`
- `STEP_DIV`, 1: number of `period_end` pulses per ±1 duty step (≥1)

Ports:
- `clk`  in  1  single system clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  global enable; low blocks grants and freezes ramping
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_duty`  in  NUM_REQ*DUTY_W  per-requester target; requester i occupies slice [i*DUTY_W +: DUTY_W]
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
- `period_end`  in  1  one-cycle pulse from the PWM counter wrap
- `duty_out`  out  DUTY_W  duty value driven to the PWM datapath
- `target_out`  out  DUTY_W  latched, clamped target
- `grant_id`  out  $clog2(NUM_REQ)  index of the last accepted requester
- `busy`  out  1  high in RAMP state
- `done`  out  1  one-cycle pulse when `duty_out` reaches the target

## Operation
- FSM states: IDLE, RAMP, DONE.
- IDLE:
  - If `en` and any `req_valid`, the round-robin winner gets `req_ready` high combinationally in the same cycle.
  - Winner selection: first valid index at or after `rr_ptr`, wrapping.
  - On the transfer edge: latch `target_out = min(req_duty[w], DUTY_MAX)`, set `grant_id = w`, set `rr_ptr = (w+1) mod NUM_REQ`.
  - Next state is RAMP if target ≠ `duty_out`, otherwise DONE.
- RAMP:
  - `req_ready` is all zero; new requests wait and are not dropped.
  - Each `period_end` with `en` high increments `step_cnt`.
  - When `step_cnt` reaches `STEP_DIV`:
    - `duty_out` moves ±1 toward `target_out`.
    - `step_cnt` clears.
    - If the new value equals the target, go to DONE.
- DONE: `done` is high for exactly one cycle, then IDLE.
- `en` low:
  - IDLE grants nothing.
  - RAMP ignores `period_end`; `step_cnt` and `duty_out` hold.
  - Already-latched state is unaffected.
- `period_end` in IDLE or DONE has no effect.
- Arithmetic:
  - `duty_out` is always within 0..DUTY_MAX.
  - Comparisons are unsigned.
  - No wrap-around is possible because of the clamp.
- Reset values:
  - State IDLE.
  - `duty_out = DUTY_INIT`, `target_out = DUTY_INIT`.
  - `grant_id = 0`, `rr_ptr = 0`, `step_cnt = 0`.
  - `busy`, `done` and `req_ready` low.
- `rst` mid-RAMP aborts the ramp immediately (asynchronously). The pending request is not re-accepted until the requester still holds valid after reset.

## Timing
- Grant: `req_ready` is asserted in the same cycle as a valid request in IDLE (combinational from state, `en`, `req_valid`, `rr_ptr`).
- `busy` rises the cycle after the transfer.
- Step latency: `duty_out` updates on the edge where the qualifying `period_end` is sampled, so the new value applies from the next PWM period.
- Total ramp time: |target − start| × STEP_DIV period_end pulses, plus 1 cycle (DONE).
- An equal target gives `done` 1 cycle after the transfer and `busy` never rises.
- Back-to-back requests: the next grant can happen at the earliest in the cycle after DONE.
- All outputs except `req_ready` are registered.

## Structure
- Package `pwm_sched_pkg`: state enum (IDLE/RAMP/DONE), default `DUTY_MAX`/`DUTY_INIT` constants.
- Sub-module `rr_arbiter`:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and index.
  - Purely combinational.
- Pointer register, FSM, step counter and duty register live in the top level.

## Test plan
- Reset with defaults: `duty_out` = 5, `target_out` = 5, `req_ready` = 0, `busy` = 0 while `rst` is high, including an assertion mid-cycle.
- Requester 0 requests 8, with `period_end` every 10 clocks: `duty_out` goes 6, 7, 8 on three successive pulses, then `done` pulses once and the FSM returns to IDLE.
- Requester 2 requests 15: `target_out` = 10 and `duty_out` ramps to 10 and stops; then a request of 0 ramps down 10 pulses to 0.
- Requesters 1 and 3 both valid from reset: 1 is granted first, then 3 after DONE; next, 0 and 1 both valid: 0 is granted (pointer wrapped).
- `en` dropped mid-ramp for 3 `period_end` pulses: `duty_out` holds. After re-enable, stepping resumes. With `STEP_DIV` = 2, steps occur every second pulse.
- `rst` asserted while RAMP is at `duty_out` = 7 toward 9: outputs return to reset values immediately, and no `done` is generated.
